nios_ram_arbiter: RTL
=====================

// Module: nios_ram_arbiter
// PURPOSE
//  Shares the single-port 4096x32 on-chip RAM between two Avalon-MM requesters.
//  m0 is the Nios II data master; m1 is the audio sample/DMA engine.
//  Sits between both masters and the RAM's s1 port.
//  Grants at most one access per clock; returns read data to the issuing master.
// PARAMETERS
//  ADDR_W   12  word-address width (RAM depth = 2**ADDR_W)
//  DATA_W   32  data width; byteenable width = DATA_W/8
// PORTS
//  clk               in   1         system clock
//  reset             in   1         synchronous, active-high reset
//  mN_address        in   ADDR_W    word address, N = 0,1
//  mN_byteenable     in   DATA_W/8  write byte lanes
//  mN_read           in   1         read request
//  mN_write          in   1         write request (read & write together is illegal)
//  mN_writedata      in   DATA_W    write data
//  mN_waitrequest    out  1         1 = request not accepted this cycle
//  mN_readdata       out  DATA_W    read data
//  mN_readdatavalid  out  1         one-cycle strobe, mN_readdata valid
//  ram_address       out  ADDR_W    to RAM address
//  ram_byteenable    out  DATA_W/8  to RAM byteenable (all ones on reads)
//  ram_chipselect    out  1         to RAM chipselect
//  ram_write         out  1         to RAM write
//  ram_writedata     out  DATA_W    to RAM writedata
//  ram_clken         out  1         tied 1
//  ram_readdata      in   DATA_W    from RAM; valid 1 cycle after address (registered address)
// BEHAVIOUR
//  - Request: reqN = mN_read | mN_write.
//  - Grant is combinational from req and the registered last_grant:
//    - Only one requester active: that requester wins.
//    - Both active: winner is !last_grant (round-robin).
//  - Winner: mN_waitrequest=0 (accepted). Loser: waitrequest=1. Idle master: waitrequest=1.
//  - Winner signals drive ram_*; ram_chipselect=1; ram_write = winner write.
//  - No request: ram_chipselect=0, ram_write=0; address/data don't-care (hold last).
//  - last_grant <= winner on every accepted cycle; unchanged when idle.
//  - Reads, cycle T accept: rd_owner register captures winner, rd_pend<=1.
//    - T+1: mN_readdatavalid=1 for owner only; mN_readdata=ram_readdata.
//  - Read latency is fixed at 1. Back-to-back reads sustain 1/cycle, mixed masters allowed.
//  - Writes complete on accept; no response strobe.
//  - mN_readdata is driven by ram_readdata for both masters; valid only with the strobe.
//  - Write then read to the same address on consecutive cycles returns new data.
//    - RAM does the write at T; the read address is registered at T+1.
//  - Illegal read & write together: treated as write; no readdatavalid.
//  - Address is passed unmodified; 0xFFF is the last word; no wrap or range check.
//  - Reset values: last_grant=1 (m0 wins first tie); rd_pend=0; rd_owner=0.
//    - Both readdatavalid=0. waitrequest follows the combinational rule (1 while reset).
//  - While reset=1: no grants, ram_chipselect=0, all waitrequest=1.
//  - Reset mid-read: the pending readdatavalid is suppressed; no stale strobe after reset.
// CONFIGURATION
//  NIOS_RAM_ARB_FIXED_PRIO_EN
//   - Defined: fixed priority, m0 always wins a tie. last_grant is still kept but ignored.
//     m1 can starve under continuous m0 traffic.
//   - Undefined (default): round-robin as above. Each master is guaranteed
//     1 grant every 2 contended cycles.
// TESTING
//  1. m0 write 0x010 <= 0xDEADBEEF (be=1111); next cycle m1 read 0x010
//     -> m1_readdatavalid=1 at T+1 with 0xDEADBEEF; m0_readdatavalid stays 0.
//  2. m0 and m1 both read continuously for 8 cycles after reset
//     -> grants m0,m1,m0,...; 4 strobes each; every waitrequest low exactly on its grant cycle.
//  3. Word 0x020=0xAAAAAAAA; m1 write 0x0000FFFF with be=0011; read back
//     -> 0xAAAAFFFF.
//  4. reset=1 in the cycle after an m1 read accept
//     -> no readdatavalid at any later cycle. After release, the first tie goes to m0.
//  5. With NIOS_RAM_ARB_FIXED_PRIO_EN, continuous ties for 8 cycles
//     -> m0 gets 8 grants, m1 waitrequest=1 throughout.
//     - m0 drops -> m1 granted the same cycle.
//  6. m0 write then read of 0xFFF, value 0x12345678 -> read returns 0x12345678.
//     - Word 0x000 stays unchanged.

Source files
------------

// File: rtl/nios_ram_arbiter_if.sv
// Avalon-MM requester bundle shared by the two masters of nios_ram_arbiter.
// Ports (per instance): address, byteenable, read, write, writedata,
//   waitrequest, readdata, readdatavalid. master = requester, slave = arbiter.
interface nios_ram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/nios_ram_arbiter.sv
// Two-master arbiter for a single-port on-chip RAM with 1-cycle read latency.
// Ports: clk, reset (sync, active-high); m0/m1 requester bundles (slave side);
//   ram_address/byteenable/chipselect/write/writedata/clken out, ram_readdata in.
// Config: NIOS_RAM_ARB_FIXED_PRIO_EN selects fixed m0 priority on ties;
//   undefined (default) gives round-robin ties.
module nios_ram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    nios_ram_arbiter_if.slave   m0,
    nios_ram_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);
    localparam int BE_W = DATA_W / 8;

    logic req0, req1, gnt0, gnt1, gnt_any;
    logic win_rd, win_wr;

    logic last_grant_q, last_grant_d;
    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;

    // RAM-side address/data hold their last value while idle.
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        req0 = m0.read | m0.write;
        req1 = m1.read | m1.write;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
`ifdef NIOS_RAM_ARB_FIXED_PRIO_EN
                gnt0 = 1'b1;
`else
                // last_grant holds the index of the previous winner.
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
`endif
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        gnt_any = gnt0 | gnt1;
    end

    always_comb begin
        // Read together with write is treated as a write.
        win_wr = (gnt0 & m0.write) | (gnt1 & m1.write);
        win_rd = ((gnt0 & m0.read) | (gnt1 & m1.read)) & !win_wr;

        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        if (gnt1) begin
            addr_d  = m1.address;
            be_d    = m1.write ? m1.byteenable : {BE_W{1'b1}};
            wdata_d = m1.writedata;
        end else if (gnt0) begin
            addr_d  = m0.address;
            be_d    = m0.write ? m0.byteenable : {BE_W{1'b1}};
            wdata_d = m0.writedata;
        end

        ram_address    = addr_d;
        ram_byteenable = be_d;
        ram_writedata  = wdata_d;
        ram_chipselect = gnt_any;
        ram_write      = win_wr;
        ram_clken      = 1'b1;

        last_grant_d = gnt_any ? gnt1 : last_grant_q;
        rd_pend_d    = win_rd;
        rd_owner_d   = win_rd ? gnt1 : rd_owner_q;

        m0.waitrequest = !gnt0;
        m1.waitrequest = !gnt1;
        m0.readdata    = ram_readdata;
        m1.readdata    = ram_readdata;
        // Gating with reset kills a strobe pending across a reset edge.
        m0.readdatavalid = rd_pend_q & !rd_owner_q & !reset;
        m1.readdatavalid = rd_pend_q &  rd_owner_q & !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
        end
    end
endmodule
